// File: rtl/alu_operand_loader_if.sv
// Operand bus from the input loader to the ALU: latched A/B/function triple,
// sticky load flags and a valid/ready handshake.
//   A, B     : latched 32-bit operands
//   ALU_OP   : latched 4-bit function code
//   loaded   : sticky {F,B,A} written-since-reset flags
//   op_valid : triple ready for the ALU
//   op_ready : ALU accepts the triple when op_valid & op_ready at a rising edge
interface alu_operand_loader_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALU_OP;
   logic [2:0]  loaded;
   logic        op_valid;
   logic        op_ready;

   modport master (
      output A,
      output B,
      output ALU_OP,
      output loaded,
      output op_valid,
      input  op_ready
   );

   modport slave (
      input  A,
      input  B,
      input  ALU_OP,
      input  loaded,
      input  op_valid,
      output op_ready
   );
endinterface

// File: rtl/alu_operand_loader.sv
// Upstream input stage for the ALU: synchronises and debounces three raw
// pushbuttons, latches the switch bank into operand A, operand B or the ALU
// function register on each debounced press, and offers the triple to the ALU.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   SW       : switch bank, data source for every load
//   btn_A/B/F: raw asynchronous pushbuttons (load A, load B, load function)
//   bus      : operand bus towards the ALU (master side)
module alu_operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 SW,
   input  logic                        btn_A,
   input  logic                        btn_B,
   input  logic                        btn_F,
   alu_operand_loader_if.master        bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned NBTN   = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, PENDING} state_e;

   // Button vectors are ordered {F,B,A} to match the loaded flags.
   logic [NBTN-1:0]   s1_q, s1_d;
   logic [NBTN-1:0]   s2_q, s2_d;
   logic [NBTN-1:0]   st_q, st_d;
   logic [NBTN-1:0]   st_dly_q, st_dly_d;
   logic [CNT_W-1:0]  cnt_q [NBTN];
   logic [CNT_W-1:0]  cnt_d [NBTN];
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [NBTN-1:0]   loaded_q, loaded_d;
   state_e            state_q, state_d;
   logic [NBTN-1:0]   pulse;
   logic              load;

   // Next-state logic: synchroniser, debounce, load registers, handshake.
   always_comb begin
      s1_d     = {btn_F, btn_B, btn_A};
      s2_d     = s1_q;
      st_d     = st_q;
      st_dly_d = st_q;
      for (int unsigned i = 0; i < NBTN; i++) begin
         cnt_d[i] = cnt_q[i];
         // Any sample agreeing with the debounced state restarts the count.
         if (s2_q[i] == st_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      // One-cycle pulse on the debounced rising edge only.
      pulse    = st_q & ~st_dly_q;
      load     = |pulse;

      a_d      = pulse[0] ? SW : a_q;
      b_d      = pulse[1] ? SW : b_q;
      op_d     = pulse[2] ? SW[OP_W-1:0] : op_q;
      loaded_d = loaded_q | pulse;

      state_d  = state_q;
      case (state_q)
         IDLE: begin
            if (load && (loaded_d == 3'b111)) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            // A load in the accept cycle supplies a fresh triple, so stay.
            if (!load && bus.op_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Single register stage; reset dominates everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         st_q     <= '0;
         st_dly_q <= '0;
         for (int unsigned i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         loaded_q <= '0;
         state_q  <= IDLE;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         st_q     <= st_d;
         st_dly_q <= st_dly_d;
         for (int unsigned i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         loaded_q <= loaded_d;
         state_q  <= state_d;
      end
   end

   assign bus.A        = a_q;
   assign bus.B        = b_q;
   assign bus.ALU_OP   = op_q;
   assign bus.loaded   = loaded_q;
   assign bus.op_valid = (state_q == PENDING);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed testbench for alu_operand_loader with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_alu_operand_loader;

   localparam int unsigned DEB = 4;

   logic        clk;
   logic        rst;
   logic [31:0] SW;
   logic        btn_A;
   logic        btn_B;
   logic        btn_F;
   int          n_tests;
   int          n_fail;

   alu_operand_loader_if bus_if ();

   alu_operand_loader #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (20)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .SW    (SW),
      .btn_A (btn_A),
      .btn_B (btn_B),
      .btn_F (btn_F),
      .bus   (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Press the selected buttons ({F,B,A}) for hold cycles, then release and
   // let the debounced state fall back to low.
   task automatic press(input logic [2:0] m, input int hold);
      {btn_F, btn_B, btn_A} = m;
      repeat (hold) tick();
      {btn_F, btn_B, btn_A} = 3'b000;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_tests++;
      if (bus_if.A !== 32'h0 || bus_if.B !== 32'h0 || bus_if.ALU_OP !== 4'h0 ||
          bus_if.loaded !== 3'b000 || bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: A=%h B=%h OP=%h loaded=%b valid=%b, want all 0",
                  bus_if.A, bus_if.B, bus_if.ALU_OP, bus_if.loaded, bus_if.op_valid);
      end
   endtask

   task automatic test_latency();
      SW    = 32'hFFFF_FFFF;
      btn_A = 1'b1;
      repeat (6) tick();
      n_tests++;
      if (bus_if.A !== 32'h0) begin
         n_fail++;
         $display("FAIL latency_early: A=%h after edge 6, want 00000000", bus_if.A);
      end
      tick();
      n_tests++;
      if (bus_if.A !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL latency_load: A=%h after edge 7, want ffffffff", bus_if.A);
      end
      n_tests++;
      if (bus_if.loaded !== 3'b001 || bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_flags: loaded=%b valid=%b, want 001/0",
                  bus_if.loaded, bus_if.op_valid);
      end
      repeat (3) tick();
      btn_A = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_triple_handshake();
      logic stable;
      bus_if.op_ready = 1'b0;
      SW = 32'h1;
      press(3'b001, 8);
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL partial_valid: op_valid=%b after A only, want 0", bus_if.op_valid);
      end
      press(3'b010, 8);
      SW = 32'h0;
      press(3'b100, 8);
      n_tests++;
      if (bus_if.op_valid !== 1'b1 || bus_if.A !== 32'h1 || bus_if.B !== 32'h1 ||
          bus_if.ALU_OP !== 4'h0 || bus_if.loaded !== 3'b111) begin
         n_fail++;
         $display("FAIL triple_loaded: valid=%b A=%h B=%h OP=%h loaded=%b, want 1/1/1/0/111",
                  bus_if.op_valid, bus_if.A, bus_if.B, bus_if.ALU_OP, bus_if.loaded);
      end
      SW = 32'h5A5A_5A5A;
      stable = 1'b1;
      repeat (20) begin
         tick();
         if (bus_if.op_valid !== 1'b1 || bus_if.A !== 32'h1 || bus_if.B !== 32'h1 ||
             bus_if.ALU_OP !== 4'h0) stable = 1'b0;
      end
      n_tests++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL pending_hold: triple or op_valid moved while pending, want steady");
      end
      bus_if.op_ready = 1'b1;
      tick();
      bus_if.op_ready = 1'b0;
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL accept: op_valid=%b after accept edge, want 0", bus_if.op_valid);
      end
      bus_if.op_ready = 1'b1;
      repeat (3) tick();
      bus_if.op_ready = 1'b0;
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: op_valid=%b with op_ready in idle, want 0", bus_if.op_valid);
      end
   endtask

   task automatic test_glitch();
      SW = 32'hDEAD_BEEF;
      for (int i = 0; i < 12; i++) begin
         btn_B = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick();
      end
      btn_B = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (bus_if.B !== 32'h1 || bus_if.loaded !== 3'b111 || bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch: B=%h loaded=%b valid=%b, want 00000001/111/0",
                  bus_if.B, bus_if.loaded, bus_if.op_valid);
      end
   endtask

   task automatic test_hold_once();
      SW    = 32'h2;
      btn_F = 1'b1;
      repeat (25) tick();
      SW = 32'h3;
      repeat (25) tick();
      btn_F = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (bus_if.ALU_OP !== 4'h2) begin
         n_fail++;
         $display("FAIL hold_once: ALU_OP=%h, want 2", bus_if.ALU_OP);
      end
      n_tests++;
      if (bus_if.op_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_pending: op_valid=%b after reload, want 1", bus_if.op_valid);
      end
      bus_if.op_ready = 1'b1;
      tick();
      bus_if.op_ready = 1'b0;
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_accept: op_valid=%b, want 0", bus_if.op_valid);
      end
   endtask

   task automatic test_back_to_back();
      SW = 32'hA000_0001;
      btn_A = 1'b1;
      btn_B = 1'b1;
      repeat (6) tick();
      n_tests++;
      if (bus_if.A !== 32'h1 || bus_if.B !== 32'h1) begin
         n_fail++;
         $display("FAIL dual_early: A=%h B=%h after edge 6, want 00000001/00000001",
                  bus_if.A, bus_if.B);
      end
      tick();
      n_tests++;
      if (bus_if.A !== 32'hA000_0001 || bus_if.B !== 32'hA000_0001 ||
          bus_if.op_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL dual_load: A=%h B=%h valid=%b, want a0000001/a0000001/1",
                  bus_if.A, bus_if.B, bus_if.op_valid);
      end
      btn_A = 1'b0;
      btn_B = 1'b0;
      repeat (10) tick();
      // Accept the dual-load triple with op_ready held; a following F load
      // then pends for exactly one cycle.
      bus_if.op_ready = 1'b1;
      tick();
      SW = 32'h5;
      btn_F = 1'b1;
      repeat (7) tick();
      n_tests++;
      if (bus_if.op_valid !== 1'b1 || bus_if.ALU_OP !== 4'h5) begin
         n_fail++;
         $display("FAIL ready_held_load: valid=%b OP=%h, want 1/5",
                  bus_if.op_valid, bus_if.ALU_OP);
      end
      tick();
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_held_accept: op_valid=%b, want 0", bus_if.op_valid);
      end
      btn_F = 1'b0;
      bus_if.op_ready = 1'b0;
      repeat (10) tick();
      // Re-enter pending via A, then land an F load exactly on the accept edge.
      SW = 32'h7;
      press(3'b001, 8);
      SW = 32'h6;
      btn_F = 1'b1;
      repeat (6) tick();
      bus_if.op_ready = 1'b1;
      tick();
      n_tests++;
      if (bus_if.op_valid !== 1'b1 || bus_if.ALU_OP !== 4'h6) begin
         n_fail++;
         $display("FAIL load_on_accept: valid=%b OP=%h, want 1/6",
                  bus_if.op_valid, bus_if.ALU_OP);
      end
      tick();
      n_tests++;
      if (bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_coincide_accept: op_valid=%b, want 0", bus_if.op_valid);
      end
      bus_if.op_ready = 1'b0;
      btn_F = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_debounce();
      SW = 32'h7;
      press(3'b001, 8);
      n_tests++;
      if (bus_if.op_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_pending: op_valid=%b, want 1", bus_if.op_valid);
      end
      SW = 32'h9;
      btn_A = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (bus_if.A !== 32'h0 || bus_if.B !== 32'h0 || bus_if.ALU_OP !== 4'h0 ||
          bus_if.loaded !== 3'b000 || bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: A=%h B=%h OP=%h loaded=%b valid=%b, want all 0",
                  bus_if.A, bus_if.B, bus_if.ALU_OP, bus_if.loaded, bus_if.op_valid);
      end
      repeat (6) tick();
      n_tests++;
      if (bus_if.A !== 32'h0) begin
         n_fail++;
         $display("FAIL fresh_early: A=%h 6 edges after reset, want 00000000", bus_if.A);
      end
      tick();
      n_tests++;
      if (bus_if.A !== 32'h9 || bus_if.loaded !== 3'b001 || bus_if.op_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fresh_load: A=%h loaded=%b valid=%b, want 00000009/001/0",
                  bus_if.A, bus_if.loaded, bus_if.op_valid);
      end
      btn_A = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      rst             = 1'b1;
      SW              = 32'h0;
      btn_A           = 1'b0;
      btn_B           = 1'b0;
      btn_F           = 1'b0;
      bus_if.op_ready = 1'b0;
      test_reset();
      test_latency();
      test_triple_handshake();
      test_glitch();
      test_hold_once();
      test_back_to_back();
      test_reset_mid_debounce();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream input stage for the ALU top level.
- Takes the raw 32-bit switch bank and three raw, bouncy pushbuttons (load A, load B, load F).
- Synchronises and debounces each button, then latches SW into the operand A, operand B or ALU-function register on the debounced press edge.
- Presents the latched triple to the ALU with a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised button must differ from its debounced state before that state flips (≥1; board builds use 1000000).
- CNT_W, 20, width of each debounce counter (must hold DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- SW  in  32  switch bank, data source for every load
- btn_A  in  1  raw async pushbutton, load operand A
- btn_B  in  1  raw async pushbutton, load operand B
- btn_F  in  1  raw async pushbutton, load ALU function
- A  out  32  latched operand A
- B  out  32  latched operand B
- ALU_OP  out  4  latched function code (SW[3:0] at load time)
- loaded  out  3  sticky flags {F,B,A}: register written since reset
- op_valid  out  1  operand triple ready for ALU
- op_ready  in  1  ALU accepts triple when op_valid & op_ready at a rising edge

Behaviour:
- Reset (rst=1 at rising edge): A=0, B=0, ALU_OP=0, loaded=3'b000, op_valid=0; all sync flops, debounced states and counters =0. Reset dominates every other event in the same cycle, including mid-debounce and pending handshake.
- Sync: per button two-flop synchroniser (s1, s2); only s2 is used downstream.
- Debounce, per button:
  - counter cnt and debounced state st.
  - If s2==st: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: st<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and never flips st.
- Press pulse: st & ~st_d (registered previous st), one cycle wide. Release generates no pulse.
- Latency: counting edge 1 as the first rising edge that samples raw=1, the target register holds SW (value sampled at the load edge) after edge DEBOUNCE_CYCLES+3. loaded and op_valid update on the same edge.
- Load: pulse_A -> A<=SW; pulse_B -> B<=SW; pulse_F -> ALU_OP<=SW[3:0] (SW[31:4] ignored). Set the corresponding loaded bit. Simultaneous pulses all load the same SW value in the same cycle.
- Holding a button produces exactly one load. A new load requires release, debounced low, then a fresh press.
- Handshake state machine, states IDLE and PENDING:
  - IDLE -> PENDING on any load edge after which loaded==3'b111. op_valid=1 in PENDING.
  - PENDING -> IDLE when op_ready=1 at an edge with no load in that cycle.
  - Load and op_ready in the same cycle: the old triple counts as accepted, the new values are latched, and the block stays PENDING (op_valid remains 1).
  - Loads while PENDING update the registers in place; op_valid stays 1.
  - A, B and ALU_OP must not change in PENDING except by a load.
- loaded bits are sticky until rst. After acceptance, reloading any single register re-enters PENDING.
- Loads before all three are loaded update registers but leave op_valid=0.
- op_ready is ignored in IDLE.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then SW=32'hFFFFFFFF and press btn_A clean for 10 cycles -> A=32'hFFFFFFFF exactly 7 edges after first high sample; loaded=3'b001; op_valid=0.
2. SW=32'h1: load A; SW=32'h1: load B; SW=32'h0: load F, with op_ready=0 -> after F, op_valid=1, A=1, B=1, ALU_OP=0, held constant 20 cycles. op_ready=1 for one cycle -> op_valid=0 next edge.
3. btn_B toggling 1,0,1,0 on alternate cycles for 12 cycles (glitch <4 cycles), then low -> B unchanged, no pulse, loaded unchanged.
4. Hold btn_F high 50 cycles with SW changing 2 -> 3 mid-hold -> one load only, ALU_OP=2.
5. btn_A and btn_B raised on the same edge with SW=32'hA0000001 -> A=B=32'hA0000001 on the same edge. Then load F with op_ready=1 held and a second F load coinciding with the accept edge -> op_valid stays 1.
6. Assert rst for one cycle while btn_A is mid-debounce (cnt=2) with PENDING active -> all outputs 0, loaded=0. btn_A still held after reset -> load occurs only after a full fresh 2+4 cycle sync/debounce.
